// File: rtl/multicycle_main_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, ALUop
// codes, datapath select codes, state encodings and the control-word layout.
package multicycle_main_control_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUop codes handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Native width of the state encoding
    localparam int STATE_BITS = 4;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // One datapath control word
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state-to-control-word decoder. Everything is a pure function
// of the current state except the FETCH load strobes and the MEMWR done pulse,
// which follow the effective memory-ready, and illegal_op in DECODE.
module multicycle_ctrl_outdec
    import multicycle_main_control_pkg::*;
(
    input  state_e     state_i,
    input  logic       rdy_i,
    input  logic [5:0] opcode_i,
    input  logic       reset_i,
    output ctrl_t      ctrl_o
);

    // Decode the control word; reset and unused encodings force all zeros
    always_comb begin
        ctrl_o = '0;
        if (reset_i) begin
            ctrl_o = '0;
        end else begin
            case (state_i)
                S_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.alu_op    = ALUOP_ADD;
                    ctrl_o.pc_source = PCSRC_ALU;
                    ctrl_o.ir_write  = rdy_i;
                    ctrl_o.pc_write  = rdy_i;
                end
                S_DECODE: begin
                    ctrl_o.alu_src_b  = SRCB_IMM_SH;
                    ctrl_o.alu_op     = ALUOP_ADD;
                    ctrl_o.illegal_op = ~op_supported(opcode_i);
                end
                S_MEMADR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_dst    = 1'b0;
                    ctrl_o.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl_o.mem_write  = 1'b1;
                    ctrl_o.i_or_d     = 1'b1;
                    ctrl_o.instr_done = rdy_i;
                end
                S_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_REG;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.reg_dst    = 1'b1;
                    ctrl_o.mem_to_reg = 1'b0;
                    ctrl_o.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_src_b     = SRCB_REG;
                    ctrl_o.alu_op        = ALUOP_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_source     = PCSRC_ALUOUT;
                    ctrl_o.instr_done    = 1'b1;
                end
                S_ADDI_EX: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_ADDI_WB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.reg_dst    = 1'b0;
                    ctrl_o.mem_to_reg = 1'b0;
                    ctrl_o.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl_o.pc_write   = 1'b1;
                    ctrl_o.pc_source  = PCSRC_JUMP;
                    ctrl_o.instr_done = 1'b1;
                end
                default: begin
                    ctrl_o = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Holds the state register
// and next-state logic; the control word comes from multicycle_ctrl_outdec.
// Outputs are zero in any cycle where reset is sampled high, so an aborted
// instruction cannot complete a memory or register write.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_e state_q;
    state_e state_d;
    logic   rdy_s;
    ctrl_t  ctrl_s;

    // With single-cycle memory every access completes immediately
    assign rdy_s = USE_MEM_READY ? mem_ready : 1'b1;

    // Next-state selection; opcode only matters in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        if (reset) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:   state_d = rdy_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    case (opcode)
                        OP_LW:   state_d = S_MEMRD;
                        OP_SW:   state_d = S_MEMWR;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEMRD:   state_d = rdy_s ? S_MEMWB : S_MEMRD;
                S_MEMWB:   state_d = S_FETCH;
                S_MEMWR:   state_d = rdy_s ? S_FETCH : S_MEMWR;
                S_EXEC:    state_d = S_RWB;
                S_RWB:     state_d = S_FETCH;
                S_BRANCH:  state_d = S_FETCH;
                S_ADDI_EX: state_d = S_ADDI_WB;
                S_ADDI_WB: state_d = S_FETCH;
                S_JUMP:    state_d = S_FETCH;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state_i  (state_q),
        .rdy_i    (rdy_s),
        .opcode_i (opcode),
        .reset_i  (reset),
        .ctrl_o   (ctrl_s)
    );

    assign pc_write      = ctrl_s.pc_write;
    assign pc_write_cond = ctrl_s.pc_write_cond;
    assign i_or_d        = ctrl_s.i_or_d;
    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign ir_write      = ctrl_s.ir_write;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign pc_source     = ctrl_s.pc_source;
    assign alu_op        = ctrl_s.alu_op;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign reg_write     = ctrl_s.reg_write;
    assign reg_dst       = ctrl_s.reg_dst;
    assign instr_done    = ctrl_s.instr_done;
    assign illegal_op    = ctrl_s.illegal_op;
    assign state         = reset ? {STATE_W{1'b0}} : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: each cycle applies opcode,
// mem_ready and reset, then compares state and the full control word against
// hand-written expectations.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst, instr_done, illegal_op;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    logic [18:0] word_s;
    assign word_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
                     reg_write, reg_dst, instr_done, illegal_op};

    // Build an expected control word in the same field order as word_s
    function automatic logic [18:0] cw(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic [1:0] pcs,
        input logic [1:0] aop, input logic asa, input logic [1:0] asb,
        input logic rw, input logic rd, input logic done, input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd, done, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance to next cycle
    task automatic cyc(input string tag, input logic [5:0] opc, input logic rdy,
                       input logic rst, input logic [3:0] es, input logic [18:0] ew);
        opcode    = opc;
        mem_ready = rdy;
        reset     = rst;
        #1;
        check({tag, ".state"}, 32'(state), 32'(es));
        check({tag, ".ctrl"}, 32'(word_s), 32'(ew));
        check({tag, ".mw_rw"}, 32'(mem_write & reg_write), 32'd0);
        check({tag, ".mr_mw"}, 32'(mem_read & mem_write), 32'd0);
        if (instr_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    logic [18:0] W0, W_FETCH, W_FSTALL, W_DEC, W_DEC_ILL, W_MEMADR, W_MEMRD, W_MEMWB;
    logic [18:0] W_MEMWR, W_MEMWR_WAIT, W_EXEC, W_RWB, W_BRANCH, W_ADDI_EX, W_ADDI_WB, W_JUMP;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, XX = 6'b111111;

    initial begin
        //              pcw pcwc iord mr mw irw m2r pcs    aop    asa asb    rw rd done ill
        W0           = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
        W_FETCH      = cw(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
        W_FSTALL     = cw(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0);
        W_DEC        = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 0);
        W_DEC_ILL    = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0, 1);
        W_MEMADR     = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0);
        W_MEMRD      = cw(0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
        W_MEMWB      = cw(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0);
        W_MEMWR      = cw(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0);
        W_MEMWR_WAIT = cw(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
        W_EXEC       = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0, 0);
        W_RWB        = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 1, 1, 0);
        W_BRANCH     = cw(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 2'b00, 0, 0, 1, 0);
        W_ADDI_EX    = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0);
        W_ADDI_WB    = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0);
        W_JUMP       = cw(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 1, 0);

        reset = 1'b1; opcode = RT; mem_ready = 1'b1;

        // Reset held two cycles
        cyc("rst0", RT, 1'b1, 1'b1, 4'd0, W0);
        cyc("rst1", RT, 1'b1, 1'b1, 4'd0, W0);

        // R-type; opcode garbage outside DECODE must not matter
        done_cnt = 0;
        cyc("r_fetch", XX, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("r_dec",   RT, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("r_exec",  XX, 1'b1, 1'b0, 4'd6, W_EXEC);
        cyc("r_rwb",   XX, 1'b1, 1'b0, 4'd7, W_RWB);
        check("r_done_cnt", 32'(done_cnt), 32'd1);

        // LW with two wait states in MEMRD: 7 cycles
        done_cnt = 0;
        cyc("lw_fetch", LW, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("lw_dec",   LW, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("lw_adr",   LW, 1'b1, 1'b0, 4'd2, W_MEMADR);
        cyc("lw_rd0",   LW, 1'b0, 1'b0, 4'd3, W_MEMRD);
        cyc("lw_rd1",   LW, 1'b0, 1'b0, 4'd3, W_MEMRD);
        cyc("lw_rd2",   LW, 1'b1, 1'b0, 4'd3, W_MEMRD);
        cyc("lw_wb",    LW, 1'b1, 1'b0, 4'd4, W_MEMWB);
        check("lw_done_cnt", 32'(done_cnt), 32'd1);

        // SW, BEQ, J back to back: 4 + 3 + 3
        done_cnt = 0;
        cyc("sw_fetch", SW, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("sw_dec",   SW, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("sw_adr",   SW, 1'b1, 1'b0, 4'd2, W_MEMADR);
        cyc("sw_wr",    SW, 1'b1, 1'b0, 4'd5, W_MEMWR);
        cyc("bq_fetch", BQ, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("bq_dec",   BQ, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("bq_br",    BQ, 1'b1, 1'b0, 4'd8, W_BRANCH);
        cyc("j_fetch",  JJ, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("j_dec",    JJ, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("j_jump",   JJ, 1'b1, 1'b0, 4'd11, W_JUMP);
        check("sbj_done_cnt", 32'(done_cnt), 32'd3);

        // ADDI with one FETCH wait state
        cyc("ai_fstall", AI, 1'b0, 1'b0, 4'd0, W_FSTALL);
        cyc("ai_fetch",  AI, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("ai_dec",    AI, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("ai_ex",     AI, 1'b1, 1'b0, 4'd9, W_ADDI_EX);
        cyc("ai_wb",     AI, 1'b1, 1'b0, 4'd10, W_ADDI_WB);

        // Unsupported opcode: flagged in DECODE, back to FETCH
        done_cnt = 0;
        cyc("ill_fetch", XX, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("ill_dec",   XX, 1'b1, 1'b0, 4'd1, W_DEC_ILL);
        cyc("ill_next",  XX, 1'b0, 1'b0, 4'd0, W_FSTALL);
        cyc("ill_refetch", RT, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("ill_dec2",  RT, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("ill_exec",  RT, 1'b1, 1'b0, 4'd6, W_EXEC);
        cyc("ill_rwb",   RT, 1'b1, 1'b0, 4'd7, W_RWB);
        check("ill_done_cnt", 32'(done_cnt), 32'd1);

        // Reset during a stalled MEMWR aborts the store
        done_cnt = 0;
        cyc("ab_fetch", SW, 1'b1, 1'b0, 4'd0, W_FETCH);
        cyc("ab_dec",   SW, 1'b1, 1'b0, 4'd1, W_DEC);
        cyc("ab_adr",   SW, 1'b1, 1'b0, 4'd2, W_MEMADR);
        cyc("ab_wait",  SW, 1'b0, 1'b0, 4'd5, W_MEMWR_WAIT);
        cyc("ab_rst",   SW, 1'b0, 1'b1, 4'd0, W0);
        cyc("ab_fetch2", SW, 1'b1, 1'b0, 4'd0, W_FETCH);
        check("ab_done_cnt", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, plus the 2-bit ALUop consumed by the ALU control decoder.
- Stalls on a memory ready handshake; flags unsupported opcodes.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (single-cycle memory).
- STATE_W, 4: width of the state register.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct field
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- reg_write  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- instr_done  out  1  one-cycle pulse in an instruction's final state
- illegal_op  out  1  one-cycle pulse on an unsupported opcode in DECODE
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset: synchronous. In the cycle reset is sampled high, all outputs are 0. Next state is FETCH.
- Reset mid-instruction: aborts the instruction with no further writes. No partial writeback.
- Outputs are Moore, decoded from state. Exception: in FETCH, ir_write and pc_write equal mem_ready (or 1 when USE_MEM_READY=0). Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00 (branch target precompute).
  - Dispatch on opcode:
    - 100011 (LW) or 101011 (SW) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (BEQ) -> BRANCH
    - 001000 (ADDI) -> ADDI_EX
    - 000010 (J) -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits for mem_ready. instr_done=1 in the mem_ready cycle, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- Latency with zero wait states, in cycles including FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- mem_write and reg_write are never high in the same cycle.
- mem_read and mem_write are never high in the same cycle.
- Unused state encodings go to FETCH with all outputs 0.
- opcode is sampled only in DECODE (and in MEMADR for the LW/SW split); it is ignored in all other states.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUop codes: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - state encodings: FETCH=0 through JUMP=11
  - alu_src_b and pc_source select codes
- One natural sub-module: multicycle_ctrl_outdec, a combinational state-to-control-word decoder. The FSM module keeps only the state register and next-state logic.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> outputs all 0 during reset; state=FETCH; mem_read=1 on the first cycle after release.
- R-type (opcode 000000), mem_ready=1 -> states FETCH, DECODE, EXEC, RWB; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulses once.
- LW with mem_ready low for 2 cycles in MEMRD -> 7 cycles total; mem_read=1 and i_or_d=1 held throughout MEMRD; reg_write=1 with mem_to_reg=1 only in MEMWB.
- SW, then BEQ, then J back-to-back -> 4 + 3 + 3 cycles; mem_write one cycle with i_or_d=1; pc_write_cond=1 with alu_op=01 in BRANCH; pc_write=1 with pc_source=10 in JUMP.
- Opcode 111111 in DECODE -> illegal_op=1 for 1 cycle; next state FETCH; no reg_write or mem_write at any point.
- Reset asserted during MEMWR with mem_ready=0 -> mem_write=0 the same cycle; FETCH next cycle; instr_done never pulses.
